alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal 1..15: cycles operands are held stable before ALU outputs are captured.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port bus_in  input  8  data bus value for operand loads.
REQ-005 SHALL have ports load_b, load_c  input  1 each  load bus_in into operand register B / C.
REQ-006 SHALL have port start  input  1  request to execute one ALU operation.
REQ-007 SHALL have port func  input  3  function code (000 ADD, 001 INC, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 NOP).
REQ-008 SHALL have port dest  input  1  result destination: 0 = register A, 1 = register D.
REQ-009 SHALL have port ready  output  1  high only in IDLE; start is accepted when start and ready are both 1.
REQ-010 SHALL have ports alu_b, alu_c  output  8 each  and alu_func  output  3  operands and code driven to the ALU.
REQ-011 SHALL have ports alu_result  input  8  and alu_sign, alu_carry, alu_zero  input  1 each  ALU outputs.
REQ-012 SHALL have ports reg_a, reg_d  output  8 each  destination registers.
REQ-013 SHALL have ports cond_sign, cond_carry, cond_zero  output  1 each  condition register.
REQ-014 SHALL have port done  output  1  one-cycle pulse at operation completion.
REQ-015 SHALL have port load_err  output  1  sticky busy-load error (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, SETUP, CAPTURE, WRITE; after reset, IDLE.
REQ-017 IDLE: on accepted start in cycle T, func and dest SHALL be latched and the FSM SHALL enter SETUP at T+1.
REQ-018 SETUP SHALL last exactly SETTLE_CYCLES cycles, counted by an internal counter, then go to CAPTURE.
REQ-019 CAPTURE SHALL last one cycle and latch alu_result and the three flags into internal holding registers at its end.
REQ-020 WRITE SHALL last one cycle, assert done, and at its end update the selected destination and cond_* from the holding registers; FSM then returns to IDLE.
REQ-021 Latency: done SHALL be high in cycle T+SETTLE_CYCLES+2; ready SHALL be 1 again in T+SETTLE_CYCLES+3.
REQ-022 alu_b/alu_c SHALL always reflect operand registers B/C; alu_func SHALL reflect the latched func.
REQ-023 func 111 (NOP): full FSM sequence and done pulse SHALL occur, but reg_a, reg_d and cond_* SHALL NOT change.
REQ-024 load_b/load_c SHALL take effect at the clock edge only when the FSM is in IDLE and start is not accepted in the same cycle; otherwise they SHALL be ignored.
REQ-025 load_b and load_c asserted together in IDLE SHALL load bus_in into both B and C.
REQ-026 start while not ready SHALL be ignored (no queuing).
REQ-027 The non-selected destination register SHALL hold its value.

Reset
REQ-028 When reset_n=0 at a rising edge: FSM to IDLE, counter, B, C, holding registers, reg_a, reg_d, cond_* and load_err SHALL be 0; latched func SHALL be 111; done SHALL be 0.
REQ-029 Reset mid-operation SHALL abort without writing any destination or flag and without a done pulse; ready SHALL be 1 in the first cycle after reset_n returns to 1.

Configuration
REQ-030 Macro ALU_SEQ_LOAD_ERR_EN defined: load_err SHALL set to 1 on any load_b or load_c ignored per REQ-024 and remain 1 until reset.
REQ-031 Macro ALU_SEQ_LOAD_ERR_EN undefined: load_err SHALL be tied to 0 and no error-detection logic SHALL be present.

Verification
REQ-032 ALU model connected, SETTLE_CYCLES=2: load B=0x7F, C=0x01, start ADD dest=0 at T -> done at T+4, reg_a=0x80, cond_sign=1, cond_carry=1, cond_zero=0, reg_d unchanged.
REQ-033 B=0x0F, C=0xF0, XOR dest=1 -> reg_d=0xFF, cond_sign=1, cond_zero=0; then AND dest=1 -> reg_d=0x00, cond_zero=1.
REQ-034 After REQ-032, start NOP -> done pulses at T+4, reg_a=0x80 and cond_* unchanged.
REQ-035 start accepted, load_b=1 with bus_in=0x55 in the next cycle -> B unchanged; load_err=1 only with ALU_SEQ_LOAD_ERR_EN, else 0.
REQ-036 reset_n=0 during CAPTURE -> no done, reg_a/reg_d/cond_* = 0, ready=1 the cycle after reset release.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one external-ALU operation per accepted start.
// An accepted start latches func/dest. SETUP holds the operands steady for
// SETTLE_CYCLES cycles. CAPTURE samples the ALU result and flags into holding
// registers. WRITE pulses done and commits the result to reg_a or reg_d and
// to cond_*. func 111 (NOP) walks the same sequence but commits nothing.
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   bus_in, load_b, load_c         operand loads (honoured only in idle, no start)
//   start, func, dest, ready       operation request / handshake
//   alu_b, alu_c, alu_func         operands and function code driven to the ALU
//   alu_result, alu_sign,
//   alu_carry, alu_zero            ALU outputs
//   reg_a, reg_d                   destination registers
//   cond_sign, cond_carry,
//   cond_zero                      condition register
//   done                           one-cycle completion pulse
//   load_err                       sticky busy-load error
//
// Build option: define ALU_SEQ_LOAD_ERR_EN to enable busy-load error detection;
// otherwise load_err is tied to 0.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_in,
    input  logic       load_b,
    input  logic       load_c,
    input  logic       start,
    input  logic [2:0] func,
    input  logic       dest,
    output logic       ready,
    output logic [7:0] alu_b,
    output logic [7:0] alu_c,
    output logic [2:0] alu_func,
    input  logic [7:0] alu_result,
    input  logic       alu_sign,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic [7:0] reg_a,
    output logic [7:0] reg_d,
    output logic       cond_sign,
    output logic       cond_carry,
    output logic       cond_zero,
    output logic       done,
    output logic       load_err
);

    localparam logic [2:0] FuncNop = 3'b111;
    localparam logic [3:0] SetupLast = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StCapture, StWrite} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] b_q, b_d, c_q, c_d;
    logic [2:0] func_q, func_d;
    logic       dest_q, dest_d;
    logic [7:0] hres_q, hres_d;
    logic       hsign_q, hsign_d, hcarry_q, hcarry_d, hzero_q, hzero_d;
    logic [7:0] a_q, a_d, d_q, d_d;
    logic       csign_q, csign_d, ccarry_q, ccarry_d, czero_q, czero_d;

    logic idle, accept, load_ok;

    assign idle    = (state_q == StIdle);
    assign accept  = idle & start;
    // Loads only land in idle cycles that do not also launch an operation.
    assign load_ok = idle & ~start;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        c_d      = c_q;
        func_d   = func_q;
        dest_d   = dest_q;
        hres_d   = hres_q;
        hsign_d  = hsign_q;
        hcarry_d = hcarry_q;
        hzero_d  = hzero_q;
        a_d      = a_q;
        d_d      = d_q;
        csign_d  = csign_q;
        ccarry_d = ccarry_q;
        czero_d  = czero_q;

        if (load_ok && load_b) b_d = bus_in;
        if (load_ok && load_c) c_d = bus_in;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    func_d  = func;
                    dest_d  = dest;
                    cnt_d   = 4'd0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = 4'd0;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCapture: begin
                hres_d   = alu_result;
                hsign_d  = alu_sign;
                hcarry_d = alu_carry;
                hzero_d  = alu_zero;
                state_d  = StWrite;
            end
            StWrite: begin
                if (func_q != FuncNop) begin
                    if (dest_q) d_d = hres_q;
                    else        a_d = hres_q;
                    csign_d  = hsign_q;
                    ccarry_d = hcarry_q;
                    czero_d  = hzero_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            b_q      <= 8'd0;
            c_q      <= 8'd0;
            func_q   <= FuncNop;
            dest_q   <= 1'b0;
            hres_q   <= 8'd0;
            hsign_q  <= 1'b0;
            hcarry_q <= 1'b0;
            hzero_q  <= 1'b0;
            a_q      <= 8'd0;
            d_q      <= 8'd0;
            csign_q  <= 1'b0;
            ccarry_q <= 1'b0;
            czero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            c_q      <= c_d;
            func_q   <= func_d;
            dest_q   <= dest_d;
            hres_q   <= hres_d;
            hsign_q  <= hsign_d;
            hcarry_q <= hcarry_d;
            hzero_q  <= hzero_d;
            a_q      <= a_d;
            d_q      <= d_d;
            csign_q  <= csign_d;
            ccarry_q <= ccarry_d;
            czero_q  <= czero_d;
        end
    end

`ifdef ALU_SEQ_LOAD_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | ((load_b | load_c) & ~load_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign ready      = idle;
    assign done       = (state_q == StWrite);
    assign alu_b      = b_q;
    assign alu_c      = c_q;
    assign alu_func   = func_q;
    assign reg_a      = a_q;
    assign reg_d      = d_q;
    assign cond_sign  = csign_q;
    assign cond_carry = ccarry_q;
    assign cond_zero  = czero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: attaches a behavioural ALU and compares the
// sequencer against a transaction-level model of operands, destinations and
// flags. Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_sequencer;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bus_in;
    logic       load_b, load_c, start, dest;
    logic [2:0] func;
    logic       ready, done, load_err;
    logic [7:0] alu_b, alu_c, alu_result, reg_a, reg_d;
    logic [2:0] alu_func;
    logic       alu_sign, alu_carry, alu_zero;
    logic       cond_sign, cond_carry, cond_zero;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    logic [7:0] m_b, m_c, m_a, m_d;
    logic       m_s, m_cy, m_z;
    logic       m_err;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_in     (bus_in),
        .load_b     (load_b),
        .load_c     (load_c),
        .start      (start),
        .func       (func),
        .dest       (dest),
        .ready      (ready),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_sign   (alu_sign),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .reg_a      (reg_a),
        .reg_d      (reg_d),
        .cond_sign  (cond_sign),
        .cond_carry (cond_carry),
        .cond_zero  (cond_zero),
        .done       (done),
        .load_err   (load_err)
    );

    // External ALU behaviour; carry for ADD/INC is the carry into bit 7,
    // for SHL it is the bit shifted out.
    function automatic logic [8:0] alu_fn(input logic [2:0] f, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [7:0] lo;
        case (f)
            3'd0: begin lo = {1'b0, b[6:0]} + {1'b0, c[6:0]}; return {lo[7], b + c}; end
            3'd1: begin lo = {1'b0, b[6:0]} + 8'd1; return {lo[7], b + 8'd1}; end
            3'd2: return {1'b0, b & c};
            3'd3: return {1'b0, b | c};
            3'd4: return {1'b0, b ^ c};
            3'd5: return {1'b0, ~b};
            3'd6: return {b[7], b[6:0], 1'b0};
            default: return 9'd0;
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_result} = alu_fn(alu_func, alu_b, alu_c);
        alu_sign = alu_result[7];
        alu_zero = (alu_result == 8'd0);
    end

    task automatic check_state(input string tag);
        checks++;
        if ({reg_a, reg_d, cond_sign, cond_carry, cond_zero}
                !== {m_a, m_d, m_s, m_cy, m_z}) begin
            errors++;
            $display("FAIL %s regs: got a=%h d=%h s%b c%b z%b want a=%h d=%h s%b c%b z%b",
                     tag, reg_a, reg_d, cond_sign, cond_carry, cond_zero,
                     m_a, m_d, m_s, m_cy, m_z);
        end
        checks++;
        if ({alu_b, alu_c, load_err} !== {m_b, m_c, m_err}) begin
            errors++;
            $display("FAIL %s operands: got b=%h c=%h err=%b want b=%h c=%h err=%b",
                     tag, alu_b, alu_c, load_err, m_b, m_c, m_err);
        end
    endtask

    task automatic do_load(input logic lb, input logic lc, input logic [7:0] v);
        load_b = lb;
        load_c = lc;
        bus_in = v;
        @(negedge clk);
        load_b = 1'b0;
        load_c = 1'b0;
        bus_in = $urandom;
        if (lb) m_b = v;
        if (lc) m_c = v;
    endtask

    // One full operation; optionally hammers start while busy.
    task automatic run_op(input logic [2:0] f, input logic d, input logic noise,
                          input string tag);
        logic [8:0] r;
        int         done_at;
        int         done_cnt;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready-before: got %b want 1", tag, ready);
        end
        r = alu_fn(f, m_b, m_c);
        start = 1'b1;
        func  = f;
        dest  = d;
        done_at  = 0;
        done_cnt = 0;
        for (int k = 1; k <= int'(S) + 5; k++) begin
            @(negedge clk);
            start = noise && (k < int'(S) + 2);
            func  = $urandom;
            dest  = $urandom;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (k == 1) begin
                checks++;
                if (alu_func !== f) begin
                    errors++;
                    $display("FAIL %s alu_func: got %b want %b", tag, alu_func, f);
                end
            end
            if (k == int'(S) + 3) begin
                checks++;
                if (ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready-after: got %b want 1", tag, ready);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (done_at != int'(S) + 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s done: got cycle %0d count %0d want cycle %0d count 1",
                     tag, done_at, done_cnt, S + 2);
        end
        if (f != 3'b111) begin
            if (d) m_d = r[7:0];
            else   m_a = r[7:0];
            m_s  = r[7];
            m_cy = r[8];
            m_z  = (r[7:0] == 8'd0);
        end
        check_state(tag);
    endtask

    task automatic test_reset;
        checks++;
        if ({ready, done, alu_func} !== {1'b1, 1'b0, 3'b111}) begin
            errors++;
            $display("FAIL reset ctl: got rdy=%b done=%b func=%b want 1 0 111",
                     ready, done, alu_func);
        end
        check_state("reset");
    endtask

    task automatic test_add;
        do_load(1'b1, 1'b0, 8'h7F);
        do_load(1'b0, 1'b1, 8'h01);
        run_op(3'd0, 1'b0, 1'b0, "add");
        checks++;
        if ({reg_a, cond_sign, cond_carry, cond_zero} !== {8'h80, 3'b110}) begin
            errors++;
            $display("FAIL add const: got a=%h scz=%b%b%b want a=80 scz=110",
                     reg_a, cond_sign, cond_carry, cond_zero);
        end
    endtask

    task automatic test_nop;
        run_op(3'd7, 1'b0, 1'b0, "nop");
        run_op(3'd7, 1'b1, 1'b1, "nop_busy_start");
    endtask

    task automatic test_logic;
        do_load(1'b1, 1'b0, 8'h0F);
        do_load(1'b0, 1'b1, 8'hF0);
        run_op(3'd4, 1'b1, 1'b0, "xor");
        checks++;
        if ({reg_d, cond_sign, cond_zero} !== {8'hFF, 2'b10}) begin
            errors++;
            $display("FAIL xor const: got d=%h s=%b z=%b want d=ff s=1 z=0",
                     reg_d, cond_sign, cond_zero);
        end
        run_op(3'd2, 1'b1, 1'b0, "and");
        checks++;
        if ({reg_d, cond_zero} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL and const: got d=%h z=%b want d=00 z=1", reg_d, cond_zero);
        end
        do_load(1'b1, 1'b1, 8'hA5);
        check_state("dual_load");
    endtask

    task automatic test_busy_load;
        // Load during the accepting cycle and in the following busy cycle.
        start  = 1'b1;
        func   = 3'b111;
        dest   = 1'b0;
        load_c = 1'b1;
        bus_in = 8'h33;
        @(negedge clk);
        start  = 1'b0;
        load_c = 1'b0;
        load_b = 1'b1;
        bus_in = 8'h55;
        @(negedge clk);
        load_b = 1'b0;
`ifdef ALU_SEQ_LOAD_ERR_EN
        m_err = 1'b1;
`endif
        for (int k = 0; k < int'(S) + 8 && ready !== 1'b1; k++) @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_load timeout: got ready=%b want 1", ready);
        end
        check_state("busy_load");
        do_load(1'b1, 1'b0, 8'h3C);
        check_state("idle_load_after_err");
    endtask

    task automatic test_random;
        logic [2:0] f;
        for (int i = 0; i < 24; i++) begin
            do_load(1'($urandom), 1'($urandom), 8'($urandom));
            f = 3'($urandom);
            run_op(f, 1'($urandom), 1'($urandom), $sformatf("rand%0d_f%0d", i, f));
        end
    endtask

    task automatic test_reset_mid;
        int done_seen;
        do_load(1'b1, 1'b1, 8'h81);
        start = 1'b1;
        func  = 3'd0;
        dest  = 1'b1;
        done_seen = 0;
        for (int k = 1; k <= int'(S) + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) done_seen++;
        end
        reset_n = 1'b0;          // asserted across the CAPTURE-ending edge
        @(negedge clk);
        if (done === 1'b1) done_seen++;
        reset_n = 1'b1;
        @(negedge clk);
        m_a = 8'd0; m_d = 8'd0; m_s = 1'b0; m_cy = 1'b0; m_z = 1'b0;
        m_b = 8'd0; m_c = 8'd0; m_err = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid ready: got %b want 1", ready);
        end
        for (int k = 0; k < int'(S) + 3; k++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_mid done: got %0d pulses want 0", done_seen);
        end
        check_state("reset_mid");
    endtask

    initial begin
        reset_n = 1'b0;
        bus_in = 8'd0; load_b = 1'b0; load_c = 1'b0;
        start = 1'b0; func = 3'd0; dest = 1'b0;
        m_a = 8'd0; m_d = 8'd0; m_b = 8'd0; m_c = 8'd0;
        m_s = 1'b0; m_cy = 1'b0; m_z = 1'b0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_nop();
        test_logic();
        test_random();
        test_busy_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
